// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin N:1 val/rdy arbiter with a one-entry registered output stage
module rr_stream_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int SW   = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    in_val,
  input  logic [NREQ*DW-1:0] in_data,
  output logic [NREQ-1:0]    in_rdy,
  output logic               out_val,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_rdy
);
  logic          out_val_q, out_val_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] src_q, src_d, ptr_q, ptr_d, win;
  logic          found, grant;
  // first valid requester after the last winner, wrapping past NREQ-1 to 0
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && in_val[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = SW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  // grant only when the stage is empty or draining; ready is held low while in reset
  always_comb begin
    grant     = rst_b & found & (!out_val_q | out_rdy);
    in_rdy    = grant ? NREQ'(1) << win : '0;
    out_val_d = grant | (out_val_q & !out_rdy);
    data_d    = grant ? in_data[int'(win)*DW +: DW] : data_q;
    src_d     = grant ? win : src_q;
    ptr_d     = grant ? win : ptr_q;
  end
  // output stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_val_q <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      ptr_q     <= SW'(NREQ - 1);
    end else begin
      out_val_q <= out_val_d;
      data_q    <= data_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
    end
  end
  assign out_val  = out_val_q;
  assign out_data = data_q;
  assign out_src  = src_q;
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: directed and randomized scoreboard checks of rr_stream_arbiter
module tb_rr_stream_arbiter;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  in_val = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_rdy;
  logic        out_val;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_rdy = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  rr_stream_arbiter #(.NREQ(4), .DW(8), .SW(2)) dut (
    .clk(clk), .rst_b(rst_b), .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy),
    .out_val(out_val), .out_data(out_data), .out_src(out_src), .out_rdy(out_rdy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  logic [5:0] seq [4];
  logic [7:0] q [$];
  logic [7:0] e;
  logic [3:0] acc;
  int         wait_c [4];
  initial begin
    in_val  = 4'b1111;
    in_data = 32'h13121110;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_val", out_val, 0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_rdy", in_rdy, 0);
    rst_b   = 1'b1;
    out_rdy = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("t2_rdy", in_rdy, 32'(4'b0001 << (i % 4)));
      step();
      chk("t2_val", out_val, 1);
      chk("t2_src", out_src, 32'(i % 4));
      chk("t2_data", out_data, 32'h10 + 32'(i % 4));
    end
    rst_b = 1'b0;
    #1;
    chk("t1_val", out_val, 0);
    chk("t1_data", out_data, 0);
    chk("t1_src", out_src, 0);
    chk("t1_rdy", in_rdy, 0);
    #1 rst_b = 1'b1;
    #1;
    chk("t1_first", in_rdy, 4'b0001);
    step();
    chk("t1_src0", out_src, 0);
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_rdy", in_rdy, 0);
      step();
      chk("t3_val", out_val, 1);
      chk("t3_src", out_src, 0);
      chk("t3_data", out_data, 8'h10);
    end
    out_rdy = 1'b1;
    #1;
    chk("t3_rel_rdy", in_rdy, 4'b0010);
    step();
    chk("t3_rel_src", out_src, 1);
    chk("t3_rel_data", out_data, 8'h11);
    chk("t3_rel_val", out_val, 1);
    in_val = 4'b0100;
    step();
    chk("t4_src", out_src, 2);
    for (int i = 0; i < 3; i++) begin
      chk("t4_rdy", in_rdy, 4'b0100);
      step();
      chk("t4_src", out_src, 2);
      chk("t4_data", out_data, 8'h12);
    end
    in_val = 4'b1010;
    step();
    chk("t5_pre", out_src, 3);
    for (int i = 0; i < 4; i++) begin
      chk("t5_rdy", in_rdy, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      step();
      chk("t5_src", out_src, (i % 2 == 0) ? 1 : 3);
    end
    in_val = 4'b0000;
    #1;
    chk("idle_rdy", in_rdy, 0);
    step();
    chk("idle_val", out_val, 0);
    chk("idle_src", out_src, 3);
    chk("idle_data", out_data, 8'h13);
    step();
    in_val = 4'b1111;
    #1;
    chk("idle_ptr", in_rdy, 4'b0001);
    step();
    in_val  = '0;
    out_rdy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      seq[i]    = '0;
      wait_c[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_val[i]) in_val[i] = ($urandom_range(0, 2) != 0);
        in_data[i*8 +: 8] = {2'(i), seq[i]};
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      chk("t6_val", out_val, 32'(q.size() != 0));
      acc = in_val & in_rdy;
      chk("t6_onehot", $countones(in_rdy) <= 1, 1);
      if (out_val && out_rdy) begin
        if (q.size() == 0) chk("t6_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("t6_data", out_data, e);
          chk("t6_src", out_src, e[7:6]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          q.push_back(in_data[i*8 +: 8]);
          chk("t6_wait", wait_c[i] <= 3, 1);
          wait_c[i] = 0;
          seq[i]    = seq[i] + 6'd1;
        end else if (in_val[i] && acc != 0) wait_c[i]++;
      end
      step();
      in_val = in_val & ~acc;
    end
    in_val  = '0;
    out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_val) begin
        if (q.size() == 0) chk("t6_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("t6_tail_data", out_data, e);
        end
      end
      step();
    end
    chk("t6_empty", q.size(), 0);
    chk("t6_idle_val", out_val, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
